// File: rtl/gray_code_counter_pkg.sv
// Shared definitions for the Gray-code encoder path: default width,
// the step operation type, and the reference binary-to-Gray function.
package gray_code_counter_pkg;

  localparam int GRAY_WIDTH_DEFAULT = 4;
  localparam int GRAY_WIDTH_MAX     = 16;

  // What the counter does on a given rising edge, in priority order.
  typedef enum logic [1:0] {
    OP_HOLD,
    OP_LOAD,
    OP_UP,
    OP_DOWN
  } op_e;

  // Binary to Gray at the maximum legal width. Narrower values are
  // zero-extended; their low bits convert correctly because the shift
  // brings a zero into the top bit of the narrower value.
  function automatic logic [GRAY_WIDTH_MAX-1:0] bin2gray(
    input logic [GRAY_WIDTH_MAX-1:0] b
  );
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/gray_code_counter_bin_to_gray.sv
// Combinational binary-to-Gray converter. It feeds the gray_out flop so
// that gray_out always leaves a register, never decode logic.
module bin_to_gray #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] bin,
  output logic [WIDTH-1:0] gray
);

  // Each Gray bit is the XOR of adjacent binary bits; the MSB passes through.
  assign gray = bin ^ (bin >> 1);

endmodule

// File: rtl/gray_code_counter.sv
// Registered up/down counter that keeps a binary count and a matching
// Gray code in flops, plus a one-cycle wrap pulse. Load beats count.
module gray_code_counter
  import gray_code_counter_pkg::*;
#(
  parameter int WIDTH = GRAY_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] bin_out,
  output logic [WIDTH-1:0] gray_out,
  output logic             wrap
);

  op_e              op;
  logic [WIDTH-1:0] nxt_bin;
  logic [WIDTH-1:0] nxt_gray;
  logic             nxt_wrap;

  // Select the operation for this edge and form the next binary value and wrap flag.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // through the case below can leave one unassigned and infer a latch.
    op       = OP_HOLD;
    nxt_bin  = bin_out;
    nxt_wrap = 1'b0;

    if (load)    op = OP_LOAD;
    else if (en) op = dn ? OP_DOWN : OP_UP;

    unique case (op)
      OP_LOAD: nxt_bin = load_val;
      OP_UP: begin
        nxt_bin  = bin_out + WIDTH'(1);
        nxt_wrap = &bin_out;
      end
      OP_DOWN: begin
        nxt_bin  = bin_out - WIDTH'(1);
        nxt_wrap = ~|bin_out;
      end
      default: ;
    endcase
  end

  // Gray value of whatever binary value is about to be registered.
  bin_to_gray #(.WIDTH(WIDTH)) u_bin_to_gray (
    .bin  (nxt_bin),
    .gray (nxt_gray)
  );

  // Binary, Gray and wrap registers; reset clears all of them without a clock.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: these are plain registers rather than a memory array, so every
    // one of them is reset; that keeps the Gray/binary invariant true from
    // the moment rst is asserted.
    if (rst) begin
      bin_out  <= '0;
      gray_out <= '0;
      wrap     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so all three registers update from
      // the same pre-edge values, independent of statement order.
      bin_out  <= nxt_bin;
      gray_out <= nxt_gray;
      wrap     <= nxt_wrap;
    end
  end

endmodule

// File: tb/tb_gray_code_counter.sv
// Self-checking bench for gray_code_counter at WIDTH=4. Expected results
// are pushed to a scoreboard queue when stimulus is driven and popped and
// compared one cycle later, after the DUT's registers have updated.
module tb_gray_code_counter;
  import gray_code_counter_pkg::*;

  localparam int W = 4;

  logic         clk;
  logic         rst;
  logic         en;
  logic         dn;
  logic         load;
  logic [W-1:0] load_val;
  logic [W-1:0] bin_out;
  logic [W-1:0] gray_out;
  logic         wrap;

  gray_code_counter #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .dn       (dn),
    .load     (load),
    .load_val (load_val),
    .bin_out  (bin_out),
    .gray_out (gray_out),
    .wrap     (wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] bin;
    logic [W-1:0] gray;
    logic         wrap;
    logic         stepped;   // en step without load: gray must change one bit
    logic [W-1:0] prev_gray;
  } exp_t;

  typedef struct {
    logic         load;
    logic         en;
    logic         dn;
    logic [W-1:0] load_val;
    logic [W-1:0] exp_bin;
    logic [W-1:0] exp_gray;
    logic         exp_wrap;
  } vec_t;

  exp_t         exp_q[$];
  logic [W-1:0] m_bin;
  int           n_cmp  = 0;
  int           n_fail = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, wanted 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] ref_gray(input logic [W-1:0] b);
    logic [15:0] g;
    g = bin2gray(16'(b));
    return g[W-1:0];
  endfunction

  function automatic logic [W-1:0] gray2bin(input logic [W-1:0] g);
    logic [W-1:0] b;
    b[W-1] = g[W-1];
    for (int i = W - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  // Drive one cycle of stimulus, then pop and compare the expectation.
  task automatic run_cycle(input string name, input logic l, input logic e,
                           input logic d, input logic [W-1:0] v, input exp_t x);
    exp_t got;
    exp_q.push_back(x);
    load = l; en = e; dn = d; load_val = v;
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      check({name, "_sb_empty"}, 16'd1, 16'd0);
    end else begin
      got = exp_q.pop_front();
      check({name, "_bin"},  16'(bin_out),  16'(got.bin));
      check({name, "_gray"}, 16'(gray_out), 16'(got.gray));
      check({name, "_wrap"}, 16'(wrap),     16'(got.wrap));
      if (got.stepped)
        check({name, "_1bit"}, 16'($countones(gray_out ^ got.prev_gray)), 16'd1);
    end
  endtask

  // Model-driven step: the bench's reference counter produces the expectation.
  task automatic step(input string name, input logic l, input logic e,
                      input logic d, input logic [W-1:0] v);
    exp_t x;
    x.prev_gray = ref_gray(m_bin);
    x.stepped   = e && !l;
    x.wrap      = 1'b0;
    if (l)      x.bin = v;
    else if (e) begin
      x.bin  = d ? m_bin - W'(1) : m_bin + W'(1);
      x.wrap = d ? (m_bin == '0) : (m_bin == '1);
    end else    x.bin = m_bin;
    x.gray = ref_gray(x.bin);
    m_bin  = x.bin;
    run_cycle(name, l, e, d, v, x);
  endtask

  vec_t vecs[$];

  initial begin
    exp_t x;

    // Load / hold / reversal vectors with spec-derived constants.
    vecs.push_back('{1'b1, 1'b1, 1'b1, 4'd9,  4'd9,  4'b1101, 1'b0}); // load wins over en/dn
    vecs.push_back('{1'b0, 1'b1, 1'b0, 4'd0,  4'd10, 4'b1111, 1'b0}); // up after load
    vecs.push_back('{1'b1, 1'b1, 1'b0, 4'd15, 4'd15, 4'b1000, 1'b0}); // load at top, no wrap
    vecs.push_back('{1'b0, 1'b1, 1'b0, 4'd0,  4'd0,  4'b0000, 1'b1}); // up wrap
    vecs.push_back('{1'b0, 1'b0, 1'b0, 4'd0,  4'd0,  4'b0000, 1'b0}); // hold clears wrap
    vecs.push_back('{1'b0, 1'b1, 1'b1, 4'd0,  4'd15, 4'b1000, 1'b1}); // down wrap
    vecs.push_back('{1'b0, 1'b1, 1'b0, 4'd0,  4'd0,  4'b0000, 1'b1}); // reversal: up wrap
    vecs.push_back('{1'b1, 1'b0, 1'b0, 4'd5,  4'd5,  4'b0111, 1'b0}); // load 5
    for (int i = 0; i < 5; i++)                                         // hold at 5
      vecs.push_back('{1'b0, 1'b0, i[0], 4'(i), 4'd5, 4'b0111, 1'b0});

    rst = 1'b1; en = 1'b0; dn = 1'b0; load = 1'b0; load_val = '0;
    m_bin = '0;

    // Reset state, before any clock edge.
    #2;
    check("rst_bin",  16'(bin_out),  16'd0);
    check("rst_gray", 16'(gray_out), 16'd0);
    check("rst_wrap", 16'(wrap),     16'd0);
    @(posedge clk); #3;
    rst = 1'b0;

    // Up count 0..15, decoding gray_out back to binary every step.
    for (int i = 1; i < 16; i++) begin
      step("up", 1'b0, 1'b1, 1'b0, '0);
      check("up_decode", 16'(gray2bin(gray_out)), 16'(m_bin));
    end
    check("up_top_gray", 16'(gray_out), 16'b1000);
    step("upwrap", 1'b0, 1'b1, 1'b0, '0);
    step("after_upwrap", 1'b0, 1'b1, 1'b0, '0);

    // Count to 6, then assert reset asynchronously mid-cycle.
    for (int i = 0; i < 5; i++) step("to6", 1'b0, 1'b1, 1'b0, '0);
    check("at6", 16'(bin_out), 16'd6);
    #2 rst = 1'b1;
    #1;
    check("arst_bin",  16'(bin_out),  16'd0);
    check("arst_gray", 16'(gray_out), 16'd0);
    check("arst_wrap", 16'(wrap),     16'd0);
    en = 1'b1;
    @(posedge clk); #1;
    check("arst_held_bin", 16'(bin_out), 16'd0);
    #2 rst = 1'b0;
    m_bin = '0;
    step("post_rst", 1'b0, 1'b1, 1'b0, '0);
    check("post_rst_gray", 16'(gray_out), 16'b0001);

    // Down through zero: 1 -> 0 -> 15 (wrap) -> 14.
    step("dn_to0", 1'b0, 1'b1, 1'b1, '0);
    step("dnwrap", 1'b0, 1'b1, 1'b1, '0);
    check("dnwrap_gray", 16'(gray_out), 16'b1000);
    step("dn_14", 1'b0, 1'b1, 1'b1, '0);
    check("dn_14_gray", 16'(gray_out), 16'b1001);

    // Table-driven vectors.
    foreach (vecs[k]) begin
      x.bin       = vecs[k].exp_bin;
      x.gray      = vecs[k].exp_gray;
      x.wrap      = vecs[k].exp_wrap;
      x.stepped   = vecs[k].en && !vecs[k].load;
      x.prev_gray = ref_gray(m_bin);
      m_bin       = vecs[k].exp_bin;
      run_cycle($sformatf("vec%0d", k), vecs[k].load, vecs[k].en, vecs[k].dn,
                vecs[k].load_val, x);
    end

    // Random mix against the model, checking the invariant each cycle.
    for (int i = 0; i < 40; i++) begin
      step("rand", ($urandom_range(0, 7) == 0), 1'($urandom), 1'($urandom), 4'($urandom));
      check("rand_inv", 16'(gray_out), 16'(ref_gray(bin_out)));
    end

    check("sb_drained", 16'(exp_q.size()), 16'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  // Watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, wanted completion");
    $fatal(1, "timeout");
  end

endmodule
